// File: rtl/iir_biquad_param_if.sv
// Sample/coefficient bus of the parametrised biquad: sample in/out with valid
// qualifiers, shadow-bank write port, bank swap and exposed filter state.
interface iir_biquad_param_if #(
   parameter int NB = 12
);
   logic signed [NB-1:0] din;
   logic                 vin;
   logic                 clear;
   logic                 coef_we;
   logic [2:0]           coef_addr;
   logic signed [NB-1:0] coef_data;
   logic                 coef_swap;
   logic signed [NB-1:0] dout;
   logic                 vout;
   logic signed [NB-1:0] v;
   logic signed [NB-1:0] v1;
   logic signed [NB-1:0] v2;

   modport master (
      output din, vin, clear, coef_we, coef_addr, coef_data, coef_swap,
      input  dout, vout, v, v1, v2
   );

   modport slave (
      input  din, vin, clear, coef_we, coef_addr, coef_data, coef_swap,
      output dout, vout, v, v1, v2
   );
endinterface

// File: rtl/iir_biquad_param.sv
// Second-order direct-form-II IIR section with shadow/active coefficient banks,
// saturating fixed-point arithmetic and an optional output register stage.
module iir_biquad_param #(
   parameter int NB   = 12,
   parameter int FRAC = 10,
   parameter int PIPE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   iir_biquad_param_if.slave bus
);
   localparam int PW = 2 * NB;
   localparam int AW = 2 * NB + 3;
   localparam int NCOEF = 5;
   localparam logic signed [NB-1:0] COEF_ONE = NB'(2 ** FRAC);

   function automatic logic signed [NB-1:0] sat(input logic signed [AW-1:0] x);
      logic signed [NB-1:0] r;
      if (x[AW-1:NB-1] == {(AW-NB+1){x[AW-1]}})
         r = x[NB-1:0];
      else if (x[AW-1])
         r = {1'b1, {(NB-1){1'b0}}};
      else
         r = {1'b0, {(NB-1){1'b1}}};
      return r;
   endfunction

   logic signed [NB-1:0] shadow [NCOEF];
   logic signed [NB-1:0] active [NCOEF];
   logic signed [NB-1:0] v1_q, v2_q;
   logic signed [NB-1:0] dout_q;
   logic                 vout_q;

   logic signed [NB-1:0] b0, b1, b2, a1, a2;
   logic signed [PW-1:0] p_a1, p_a2, p_b0, p_b1, p_b2;
   logic signed [AW-1:0] w_acc, w_shr, y_acc, y_shr;
   logic signed [NB-1:0] w, y;
   logic                 accept;

   assign b0 = active[0];
   assign b1 = active[1];
   assign b2 = active[2];
   assign a1 = active[3];
   assign a2 = active[4];

   // Products are exact in 2*NB bits; sums get 3 guard bits before saturation.
   assign p_a1  = PW'(a1) * PW'(v1_q);
   assign p_a2  = PW'(a2) * PW'(v2_q);
   assign w_acc = (AW'(bus.din) <<< FRAC) - AW'(p_a1) - AW'(p_a2);
   assign w_shr = w_acc >>> FRAC;
   assign w     = sat(w_shr);

   assign p_b0  = PW'(b0) * PW'(w);
   assign p_b1  = PW'(b1) * PW'(v1_q);
   assign p_b2  = PW'(b2) * PW'(v2_q);
   assign y_acc = AW'(p_b0) + AW'(p_b1) + AW'(p_b2);
   assign y_shr = y_acc >>> FRAC;
   assign y     = sat(y_shr);

   assign accept = bus.vin & ~bus.clear;

   // Swap copies the pre-write shadow: both use the register values before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) begin
            shadow[i] <= (i == 0) ? COEF_ONE : '0;
            active[i] <= (i == 0) ? COEF_ONE : '0;
         end
      end else begin
         if (bus.coef_swap) begin
            for (int i = 0; i < NCOEF; i++)
               active[i] <= shadow[i];
         end
         if (bus.coef_we && (bus.coef_addr < 3'd5))
            shadow[bus.coef_addr] <= bus.coef_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= '0;
         v2_q <= '0;
      end else if (bus.clear) begin
         v1_q <= '0;
         v2_q <= '0;
      end else if (bus.vin) begin
         v2_q <= v1_q;
         v1_q <= w;
      end
   end

   generate
      if (PIPE == 0) begin : g_direct
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_q <= '0;
               vout_q <= 1'b0;
            end else begin
               vout_q <= accept;
               if (accept)
                  dout_q <= y;
            end
         end
      end else begin : g_piped
         logic signed [NB-1:0] y_p;
         logic                 v_p;

         // A sample already in this stage still emerges even when CLEAR hits.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y_p    <= '0;
               v_p    <= 1'b0;
               dout_q <= '0;
               vout_q <= 1'b0;
            end else begin
               v_p    <= accept;
               if (accept)
                  y_p <= y;
               vout_q <= v_p;
               if (v_p)
                  dout_q <= y_p;
            end
         end
      end
   endgenerate

   assign bus.dout = dout_q;
   assign bus.vout = vout_q;
   assign bus.v    = w;
   assign bus.v1   = v1_q;
   assign bus.v2   = v2_q;
endmodule

// File: tb/tb_iir_biquad_param.sv
// Bench for iir_biquad_param: PIPE=0 and PIPE=1 instances driven in lockstep
// and compared against an integer-arithmetic model of the biquad.
module tb_iir_biquad_param;
   localparam int NB   = 12;
   localparam int FRAC = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   iir_biquad_param_if #(.NB(NB)) bus0 ();
   iir_biquad_param_if #(.NB(NB)) bus1 ();

   iir_biquad_param #(.NB(NB), .FRAC(FRAC), .PIPE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   iir_biquad_param #(.NB(NB), .FRAC(FRAC), .PIPE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int errors = 0;
   int checks = 0;

   longint m_sh [5];
   longint m_act [5];
   longint m_v1, m_v2;
   longint e_dout0, e_dout1, p_y;
   bit     e_vout0, e_vout1, p_v;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint x);
      longint hi = (64'sd1 <<< (NB - 1)) - 1;
      longint lo = -(64'sd1 <<< (NB - 1));
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   function automatic longint calc_w(input longint din);
      return sat((din * (64'sd1 <<< FRAC) - m_act[3] * m_v1 - m_act[4] * m_v2) >>> FRAC);
   endfunction

   function automatic longint calc_y(input longint w);
      return sat((m_act[0] * w + m_act[1] * m_v1 + m_act[2] * m_v2) >>> FRAC);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_sh[i]  = (i == 0) ? (64'sd1 <<< FRAC) : 0;
         m_act[i] = m_sh[i];
      end
      m_v1 = 0; m_v2 = 0;
      e_dout0 = 0; e_dout1 = 0; p_y = 0;
      e_vout0 = 0; e_vout1 = 0; p_v = 0;
   endtask

   task automatic drive(input bit vin, input longint din, input bit clear, input bit we,
                        input logic [2:0] addr, input longint data, input bit swap);
      bus0.vin = vin;  bus0.din = NB'(din);  bus0.clear = clear;
      bus0.coef_we = we;  bus0.coef_addr = addr;  bus0.coef_data = NB'(data);
      bus0.coef_swap = swap;
      bus1.vin = vin;  bus1.din = NB'(din);  bus1.clear = clear;
      bus1.coef_we = we;  bus1.coef_addr = addr;  bus1.coef_data = NB'(data);
      bus1.coef_swap = swap;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_dout0"}, bus0.dout, 32'(e_dout0));
      chk({tag, "_vout0"}, bus0.vout, 32'(e_vout0));
      chk({tag, "_dout1"}, bus1.dout, 32'(e_dout1));
      chk({tag, "_vout1"}, bus1.vout, 32'(e_vout1));
      chk({tag, "_v1"}, bus0.v1, 32'(m_v1));
      chk({tag, "_v2"}, bus0.v2, 32'(m_v2));
      chk({tag, "_p_v1"}, bus1.v1, 32'(m_v1));
      chk({tag, "_p_v2"}, bus1.v2, 32'(m_v2));
   endtask

   // One clock of stimulus, entered and left at a falling edge.
   task automatic step(input string tag, input bit vin, input longint din,
                       input bit clear = 0, input bit we = 0, input logic [2:0] addr = 0,
                       input longint data = 0, input bit swap = 0);
      longint w, y;
      bit acc;
      drive(vin, din, clear, we, addr, data, swap);
      #1;
      w = calc_w(din);
      y = calc_y(w);
      chk({tag, "_w0"}, bus0.v, 32'(w));
      chk({tag, "_w1"}, bus1.v, 32'(w));
      @(posedge clk);
      acc = vin && !clear;
      e_vout1 = p_v;
      if (p_v) e_dout1 = p_y;
      p_v = acc;
      if (acc) p_y = y;
      e_vout0 = acc;
      if (acc) e_dout0 = y;
      if (clear) begin
         m_v1 = 0; m_v2 = 0;
      end else if (vin) begin
         m_v2 = m_v1; m_v1 = w;
      end
      if (swap) for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      if (we && addr < 3'd5) m_sh[addr] = data;
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   longint pass_in [4] = '{100, -300, 2047, -2048};
   longint decay [10] = '{400, 200, 100, 50, 25, 12, 6, 3, 1, 0};

   initial begin
      longint din, data;
      bit vin, clr, we, sw;
      logic [2:0] addr;

      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Pass-through with reset coefficients
      for (int i = 0; i < 4; i++) begin
         step("pass", 1, pass_in[i]);
         chk("pass_val", bus0.dout, 32'(pass_in[i]));
         chk("pass_vld", bus0.vout, 1);
      end
      step("idle", 0, 0);
      chk("idle_hold", bus0.dout, -2048);
      step("idle", 0, 0);

      // Single-pole decay, a1 = -0.5
      step("ld_a1", 0, 0, 0, 1, 3'd3, -512);
      step("swap", 0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         step("decay", 1, (i == 0) ? 400 : 0);
         chk("decay_val", bus0.dout, 32'(decay[i]));
         chk("decay_v1", bus0.v1, 32'(decay[i]));
      end

      // Saturation with a1 = -1.0
      step("ld_sat", 0, 0, 0, 1, 3'd3, -1024);
      step("swap", 0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step("satp", 1, 2047);
         chk("satp_val", bus0.dout, 2047);
      end
      step("clr", 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step("satn", 1, -2048);
         chk("satn_val", bus0.dout, -2048);
      end

      // Swap timing on a constant stream
      step("ld_a0", 0, 0, 1, 1, 3'd3, 0);
      step("swap", 0, 0, 1, 0, 0, 0, 1);
      step("cst", 1, 512);
      step("cst_we", 1, 512, 0, 1, 3'd0, 512);
      chk("cst_we_val", bus0.dout, 512);
      step("cst_sw", 1, 512, 0, 0, 0, 0, 1);
      chk("cst_sw_old", bus0.dout, 512);
      step("cst_new", 1, 512);
      chk("cst_sw_new", bus0.dout, 256);

      // CLEAR with VIN, then PIPE=1 impulse
      step("clrv", 1, 5, 1);
      chk("clrv_nov", bus0.vout, 0);
      chk("clrv_v1", bus0.v1, 0);
      step("ld_b0", 0, 0, 0, 1, 3'd0, 1024, 0);
      step("swap", 0, 0, 0, 0, 0, 0, 1);
      step("imp", 1, 7);
      chk("imp_lat1", bus1.vout, 0);
      step("imp_z", 0, 0);
      chk("imp_dout1", bus1.dout, 7);
      chk("imp_vout1", bus1.vout, 1);
      step("imp_z", 0, 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         vin  = ($urandom_range(0, 3) != 0);
         din  = longint'(int'($urandom_range(0, 4095)) - 2048);
         clr  = ($urandom_range(0, 19) == 0);
         we   = ($urandom_range(0, 7) == 0);
         addr = 3'($urandom_range(0, 7));
         data = (addr == 3'd3 || addr == 3'd4) ?
                longint'(int'($urandom_range(0, 2047)) - 1024) :
                longint'(int'($urandom_range(0, 4095)) - 2048);
         sw   = ($urandom_range(0, 9) == 0);
         step("rnd", vin, din, clr, we, addr, data, sw);
      end

      // Asynchronous reset mid-stream
      step("pre_rst", 1, 333);
      drive(1, 111, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_idle", 0, 0);
      step("post_sw", 0, 0, 0, 0, 0, 0, 1);
      step("post", 1, 321);
      chk("post_pass", bus0.dout, 321);
      step("post_z", 0, 0);
      chk("post_pass1", bus1.dout, 321);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
